// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: width helpers
// for the occupancy counter and pointers, and the read-mode encoding.
package fifo_pkg;

    // Read-path mode: registered read or first-word-fall-through.
    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Bits needed to address entries 0..depth-1 (at least 1 for depth 2).
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH register array: one synchronous write port and one
// asynchronous read port. Contents are never reset.
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Store the write word at the write address on an accepted write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// levels, sticky overflow/underflow flags and optional first-word-fall-through.
//
// Handshake: w_en and r_en are requests, not held handshakes. A read is
// accepted when the FIFO is not empty; a write is accepted when the FIFO is
// not full, or when a read is accepted in the same cycle (so a full FIFO can
// be written while it is being read). A rejected request is dropped and
// raises the matching sticky error flag.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      w_en,
    input  logic [WIDTH-1:0]          data_in,
    input  logic                      r_en,
    output logic [WIDTH-1:0]          data_out,
    output logic                      dout_valid,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      clr_err
);

    localparam int CW = cnt_w(DEPTH);
    localparam int PW = ptr_w(DEPTH);
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    if (DEPTH < 2) begin : g_bad_depth
        $error("fifo_sync_param: DEPTH must be at least 2");
    end
    if (AF_LEVEL > DEPTH) begin : g_bad_af
        $error("fifo_sync_param: AF_LEVEL must not exceed DEPTH");
    end
    if (AE_LEVEL > DEPTH) begin : g_bad_ae
        $error("fifo_sync_param: AE_LEVEL must not exceed DEPTH");
    end

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             rd_acc, wr_acc;
    logic [WIDTH-1:0] ram_rdata;

    // Pointers wrap by explicit compare so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Level flags decode the registered count.
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign rd_acc = r_en && !empty;
    assign wr_acc = w_en && (!full || rd_acc);

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // Next pointers, occupancy and sticky errors (a new error beats clr_err).
    always_comb begin
        wr_ptr_d    = wr_acc ? ptr_next(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = rd_acc ? ptr_next(rd_ptr_q) : rd_ptr_q;
        count_d     = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end
        overflow_d  = clr_err ? 1'b0 : overflow_q;
        underflow_d = clr_err ? 1'b0 : underflow_q;
        if (w_en && !wr_acc) begin
            overflow_d = 1'b1;
        end
        if (r_en && !rd_acc) begin
            underflow_d = 1'b1;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    if (MODE == FIFO_STD) begin : g_std
        logic [WIDTH-1:0] data_out_q, data_out_d;
        logic             dout_valid_q, dout_valid_d;

        // Registered read: capture the head on an accepted read, pulse valid.
        always_comb begin
            data_out_d   = data_out_q;
            dout_valid_d = 1'b0;
            if (rd_acc) begin
                data_out_d   = ram_rdata;
                dout_valid_d = 1'b1;
            end
        end

        // Read data register; holds its word between reads.
        always_ff @(posedge clk) begin
            if (rst) begin
                data_out_q   <= '0;
                dout_valid_q <= 1'b0;
            end else begin
                data_out_q   <= data_out_d;
                dout_valid_q <= dout_valid_d;
            end
        end

        assign data_out   = data_out_q;
        assign dout_valid = dout_valid_q;
    end else begin : g_fwft
        // Head word is presented directly; meaningful only while not empty.
        assign data_out   = ram_rdata;
        assign dout_valid = !empty;
    end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised single-clock FIFO, successor to the fixed 8-bit FIFO.
- Adds configurable width and depth, any depth ≥ 2 (not only powers of two).
- Adds an occupancy count, programmable almost-full / almost-empty flags, sticky overflow/underflow error flags, and a first-word-fall-through (FWFT) read mode.
- Sits between producer/consumer blocks sharing one clock domain.

Parameters:
- WIDTH, 8: data word width in bits.
- DEPTH, 16: number of entries; legal range ≥ 2, any integer.
- AF_LEVEL, DEPTH-2: almost_full asserts when count ≥ AF_LEVEL.
- AE_LEVEL, 2: almost_empty asserts when count ≤ AE_LEVEL.
- FWFT, 0: 0 = registered read (1-cycle latency); 1 = head word visible on data_out while not empty.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- w_en  in  1  write request.
- data_in  in  WIDTH  write data.
- r_en  in  1  read request.
- data_out  out  WIDTH  read data.
- dout_valid  out  1  data_out holds a freshly read word (FWFT=0: pulse; FWFT=1: equals !empty).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky: write rejected.
- underflow  out  1  sticky: read rejected.
- clr_err  in  1  clears overflow/underflow.

Behaviour:
- Reset (rst=1 at clk edge): pointers=0, count=0, data_out=0, dout_valid=0, overflow=underflow=0. Resulting levels: empty=1, full=0, almost_empty=1, almost_full = (AF_LEVEL==0). Memory contents are not reset.
- Reset mid-operation discards all stored words; requests in the reset cycle are ignored.
- Read accept: rd_acc = r_en && !empty.
- Write accept: wr_acc = w_en && (!full || rd_acc), so a write to a full FIFO succeeds when a read is accepted in the same cycle.
- Empty FIFO with w_en && r_en: write accepted, read rejected; underflow sets.
- Count update: +1 on wr_acc only, −1 on rd_acc only, unchanged on both or neither.
- Pointers: rd_ptr/wr_ptr advance on their accept, wrapping from DEPTH-1 to 0 (explicit compare, not modulo-2^n).
- Flags: full, empty, almost_* are combinational decodes of the registered count, so they change in the cycle after the causing edge.
- FWFT=0 read path: on rd_acc, data_out <= mem[rd_ptr] and dout_valid <= 1. Otherwise data_out holds and dout_valid <= 0. Read latency is 1 cycle.
- FWFT=1 read path: data_out = mem[rd_ptr] combinationally while !empty; r_en pops the head. A word written into an empty FIFO is visible the cycle after the write edge. data_out is don't-care while empty; the bench must not check it then.
- Error flags: overflow <= 1 when w_en && !wr_acc; underflow <= 1 when r_en && !rd_acc. Both clear on clr_err. If clr_err coincides with a new error, set wins.
- Illegal parameters (DEPTH<2, AF_LEVEL>DEPTH, AE_LEVEL>DEPTH) trigger an elaboration-time $error.

Decomposition:
- Package fifo_pkg holds:
  - function cnt_w(depth) returning $clog2(depth+1);
  - function ptr_w(depth) returning $clog2(depth);
  - a constant enum for FWFT mode {FIFO_STD=0, FIFO_FWFT=1}.
- One sub-module, fifo_ram: a DEPTH×WIDTH register array with one synchronous write port and one asynchronous read port, instantiated by fifo_sync_param.
- Pointer, count, flag and error logic stay in the top module.

Test Plan:
- Reset, then write 0xAA and 0xBB, read twice (FWFT=0, DEPTH=4, WIDTH=8) -> data_out=0xAA with dout_valid one cycle after first r_en, then 0xBB; empty=1 and count=0 afterwards.
- Write 5 words 0x01..0x05 into DEPTH=4 -> full=1 after 4th write; 5th rejected; overflow=1; count=4; reads return 0x01..0x04 in order.
- Read from empty after reset -> underflow=1, data_out stays 0, count stays 0; clr_err pulse -> underflow=0.
- Fill DEPTH=4 full, assert w_en=r_en=1 with data_in=0x55 -> count stays 4, no overflow, 0x55 read out last. Repeat for 10 cycles with DEPTH=5 to verify pointer wrap at non-power-of-2 depth.
- DEPTH=16, AF_LEVEL=14, AE_LEVEL=2: write 14 words -> almost_full rises exactly when count becomes 14. Read 12 -> almost_empty rises when count becomes 2.
- FWFT=1: write 0x3C into empty -> data_out=0x3C and dout_valid=1 the next cycle with no r_en. Assert rst during a 3-word burst -> count=0, empty=1 on the next cycle.
